// File: rtl/mul_ucode_seq.sv
// Iterative radix-2 shift-add multiply sequencer beside the fetch stage.
// Decodes MUL from the fetched word, raises mul_trigger combinationally to
// freeze fetch, runs exactly XLEN shift-add steps, then writes the low XLEN
// product bits back and pulses mul_release for one cycle.
module mul_ucode_seq #(
    parameter logic [6:0] MUL_OPCODE = 7'b0011000,
    parameter int         XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     fetched_instr,
    input  logic            flush,
    output logic [3:0]      rs1_addr,
    output logic [3:0]      rs2_addr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            mul_trigger,
    output logic            mul_release,
    output logic            busy,
    output logic            wb_en,
    output logic [3:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] acc, mcand, mplier, acc_sum;
    logic [CW-1:0]   count;
    logic [3:0]      rd;

    // Register-file read addresses come straight off the fetched word so the
    // operands arrive in the same cycle the trigger is decoded.
    assign rs1_addr = fetched_instr[20:17];
    assign rs2_addr = fetched_instr[16:13];

    // Start only from IDLE; a flush or reset in the same cycle wins over MUL.
    assign mul_trigger = (state == IDLE) && (fetched_instr[31:25] == MUL_OPCODE)
                         && !flush && !rst;
    assign busy        = (state != IDLE);

    // Partial-sum candidate for this BUSY step (wraps mod 2^XLEN).
    assign acc_sum = mplier[0] ? acc + mcand : acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: DONE is a single cycle; BUSY runs until the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_trigger) state_nxt = BUSY;
            BUSY:    if (count == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs; wb_en/mul_release are set on
    // the edge entering DONE so they are high exactly during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
            rd          <= '0;
            wb_en       <= 1'b0;
            mul_release <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
        end else begin
            wb_en       <= 1'b0;
            mul_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_trigger) begin
                        rd     <= fetched_instr[24:21];
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        count  <= CW'(XLEN);
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        wb_data     <= acc_sum;
                        wb_addr     <= rd;
                        wb_en       <= 1'b1;
                        mul_release <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ucode_seq.sv
// Bench for mul_ucode_seq: a cycle-count/product model (plain multiply plus a
// remaining-cycles counter) checked against the DUT on every negedge, with
// directed scenarios pinned by literal products and writeback counts, then
// a randomized phase mixing MUL words, flushes and resets.
module tb_mul_ucode_seq;

    localparam logic [6:0] OP = 7'b0011000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetched_instr = '0;
    logic        flush = 1'b0;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [31:0] op_a = '0, op_b = '0;
    logic        mul_trigger, mul_release, busy, wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    int compared = 0;
    int mismatched = 0;

    // model state
    bit          chk_on = 1'b0;
    int          busy_left = 0;   // 0 = idle, 33 right after trigger, 1 = writeback cycle
    logic [31:0] exp_data;
    logic [3:0]  exp_addr;
    logic [31:0] last_wb_data = '0;
    logic [3:0]  last_wb_addr = '0;
    int          wb_cnt = 0;

    mul_ucode_seq #(.MUL_OPCODE(OP), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .fetched_instr(fetched_instr), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .op_a(op_a), .op_b(op_b),
        .mul_trigger(mul_trigger), .mul_release(mul_release), .busy(busy),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_mul(input logic [3:0] rd);
        logic [31:0] w;
        w = $urandom;
        w[31:25] = OP;
        w[24:21] = rd;
        return w;
    endfunction

    function automatic logic [31:0] mk_other();
        logic [31:0] w;
        w = $urandom;
        if (w[31:25] == OP) w[31:25] = ~OP;
        return w;
    endfunction

    // Drive one input set for n cycles; inputs change just after the edge.
    task automatic step(input logic [31:0] i, input logic f, input logic r,
                        input logic [31:0] a, input logic [31:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            fetched_instr = i; flush = f; rst = r; op_a = a; op_b = b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(mk_other(), 1'($urandom), 1'b0, $urandom, $urandom, 1);
    endtask

    // Model check + advance, once per cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            logic exp_trig;
            logic [63:0] prod;
            exp_trig = (busy_left == 0) && (fetched_instr[31:25] == OP) && !flush && !rst;
            chk("mul_trigger", 32'(mul_trigger), 32'(exp_trig));
            chk("busy", 32'(busy), 32'(busy_left != 0));
            chk("wb_en", 32'(wb_en), 32'(busy_left == 1));
            chk("mul_release", 32'(mul_release), 32'(busy_left == 1));
            chk("rs1_addr", 32'(rs1_addr), 32'(fetched_instr[20:17]));
            chk("rs2_addr", 32'(rs2_addr), 32'(fetched_instr[16:13]));
            if (busy_left == 1) begin
                chk("wb_data", wb_data, exp_data);
                chk("wb_addr", 32'(wb_addr), 32'(exp_addr));
            end
            if (wb_en === 1'b1) begin
                wb_cnt++;
                last_wb_data = wb_data;
                last_wb_addr = wb_addr;
            end
            if (rst) busy_left = 0;
            else if (exp_trig) begin
                prod      = 64'(op_a) * 64'(op_b);
                exp_data  = prod[31:0];
                exp_addr  = fetched_instr[24:21];
                busy_left = 33;
            end else if (busy_left > 0) busy_left--;
        end
    end

    // One MUL followed by enough idle cycles to see its writeback.
    task automatic one_mul(input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want, input string name);
        int c0;
        c0 = wb_cnt;
        step(mk_mul(rd), 1'b0, 1'b0, a, b, 1);
        idle(36);
        chk({name, "_data"}, last_wb_data, want);
        chk({name, "_addr"}, 32'(last_wb_addr), 32'(rd));
        chk({name, "_wbcnt"}, 32'(wb_cnt - c0), 32'd1);
    endtask

    initial begin
        int c0;
        logic [31:0] w;
        // reset state
        step(mk_other(), 1'b0, 1'b1, 0, 0, 3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_release", 32'(mul_release), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk_on = 1'b1;
        step(mk_other(), 1'b0, 1'b1, 0, 0, 1);
        idle(3);

        // basic, wrap/signed, zero, identity
        one_mul(4'd3, 32'd7, 32'd6, 32'd42, "basic");
        one_mul(4'd9, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, "neg1x5");
        one_mul(4'd1, 32'h8000_0000, 32'd2, 32'h0000_0000, "wrap");
        one_mul(4'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, "zero_rd0");
        one_mul(4'd15, 32'd1, 32'h1234_5678, 32'h1234_5678, "ident");

        // flush collision then same word without flush
        c0 = wb_cnt;
        w = mk_mul(4'd6);
        step(w, 1'b1, 1'b0, 32'd3, 32'd4, 1);
        chk("flush_busy", 32'(busy), 32'd0);
        step(w, 1'b0, 1'b0, 32'd3, 32'd4, 1);
        chk("postflush_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 35; k++) step(mk_other(), 1'b1, 1'b0, $urandom, $urandom, 1);
        chk("flush_data", last_wb_data, 32'd12);
        chk("flush_wbcnt", 32'(wb_cnt - c0), 32'd1);

        // back-to-back: MUL word held through DONE and beyond the second wb
        c0 = wb_cnt;
        w = mk_mul(4'd5);
        for (int k = 0; k < 68; k++) step(w, 1'b0, 1'b0, 32'd10 + 32'(k), 32'd3, 1);
        idle(2);
        chk("b2b_wbcnt", 32'(wb_cnt - c0), 32'd2);
        chk("b2b_second", last_wb_data, 32'd132);   // second trigger at T+34: op_a=44

        // reset mid-op: abort, nothing written, then a clean MUL
        c0 = wb_cnt;
        step(mk_mul(4'd2), 1'b0, 1'b0, 32'd100, 32'd100, 1);
        idle(9);
        step(mk_other(), 1'b0, 1'b1, 0, 0, 1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        idle(30);
        chk("rst_mid_wbcnt", 32'(wb_cnt - c0), 32'd0);
        one_mul(4'd4, 32'd9, 32'd11, 32'd99, "after_rst");

        // randomized mix
        for (int k = 0; k < 3000; k++) begin
            w = ($urandom_range(0, 2) == 0) ? mk_mul(4'($urandom)) : mk_other();
            step(w, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0,
                 $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom, 1);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_ucode_seq.md
Name: mul_ucode_seq

Overview:
- Iterative multiply sequencer next to the fetch stage; generates the fetch stage's `mul_trigger` / `mul_release` handshake.
- Decodes MUL from the fetched instruction word and raises `mul_trigger` in the same cycle. Fetch then freezes its PC in the microcode state.
- Computes a 32x32 product (low 32 bits) by radix-2 shift-add, writes it back to the register file, and pulses `mul_release` to unfreeze fetch.

Parameters:
- MUL_OPCODE, 7'b0011000, value of instr[31:25] that identifies MUL.
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- fetched_instr  input  32  raw instruction word presented to fetch this cycle.
- flush  input  1  exe conditional/register branch override active this cycle; suppresses MUL start.
- rs1_addr  output  4  instr[20:17], combinational, to register-file read port A.
- rs2_addr  output  4  instr[16:13], combinational, to register-file read port B.
- op_a  input  XLEN  register-file read data for rs1_addr (same cycle).
- op_b  input  XLEN  register-file read data for rs2_addr (same cycle).
- mul_trigger  output  1  combinational start request to fetch.
- mul_release  output  1  one-cycle pulse; fetch leaves microcode state.
- busy  output  1  high while sequencing (BUSY or DONE).
- wb_en  output  1  one-cycle register-file write enable.
- wb_addr  output  4  destination register, instr[24:21] captured at start.
- wb_data  output  XLEN  product low XLEN bits.

Behaviour:
- States: IDLE, BUSY, DONE. Reset → IDLE.
- Registered outputs reset to 0: `mul_release`, `wb_en`, `wb_addr`, `wb_data`. Internal accumulator, multiplicand, multiplier and count also reset to 0.
- `mul_trigger` = (state==IDLE) && (fetched_instr[31:25]==MUL_OPCODE) && !flush && !rst. No other term.
- `busy` = (state!=IDLE).
- IDLE with `mul_trigger` high:
  - latch rd=instr[24:21], mcand=op_a, mplier=op_b;
  - acc=0, count=XLEN;
  - → BUSY.
- IDLE without `mul_trigger`: stay; all outputs idle.
- BUSY, each cycle:
  - if mplier[0], acc ← acc + mcand (mod 2^XLEN);
  - mcand ← mcand<<1, mplier ← mplier>>1, count ← count−1;
  - on the cycle count reaches 1, load `wb_data` with the final acc value and → DONE.
  - Exactly XLEN BUSY cycles, no early exit.
- DONE, one cycle only:
  - `wb_en`=1, `mul_release`=1, `wb_addr`=rd, `wb_data`=product;
  - → IDLE.
- Latency: trigger in cycle T; BUSY T+1..T+XLEN; DONE (wb/release) at T+XLEN+1. IDLE at T+XLEN+2.
- Signed and unsigned operands give identical low-half results; no high half, no overflow flag.
- Opcode on `fetched_instr` is ignored in BUSY/DONE: fetch holds PC, so the word may still or again be a MUL.
- A MUL present in the DONE cycle is not started then. It triggers in the following IDLE cycle.
- `flush` and MUL opcode in the same cycle: no trigger, state stays IDLE. Fetch's override path wins.
- `flush` during BUSY/DONE: ignored; the sequence completes.
- rd = 0: writeback is still issued; the register file decides.
- Reset mid-operation (BUSY or DONE): on the next edge go to IDLE, `wb_en`=0, `mul_release`=0. The aborted result is never written.
- `wb_en` and `mul_release` are always asserted together and never for more than one cycle per trigger.

Test Plan:
- Basic multiply: MUL rd=3, op_a=7, op_b=6 at T → `mul_trigger`=1 at T only; `busy` T+1..T+33; `wb_en`/`mul_release`=1 at T+33 with wb_addr=3, wb_data=42; idle at T+34.
- Wrap and signed: op_a=0xFFFFFFFF (−1), op_b=5 → wb_data=0xFFFFFFFB. Separately op_a=0x80000000, op_b=2 → wb_data=0x00000000.
- Flush collision: MUL opcode with flush=1 → `mul_trigger`=0, `busy` stays 0, no wb. Same word next cycle with flush=0 → trigger.
- Back-to-back: MUL at T and a MUL word held through DONE (T+33) → second trigger at T+34; second wb at T+67; exactly two `wb_en` pulses.
- Reset mid-op: assert rst at T+10 → `busy`=0 from T+11; no `wb_en`/`mul_release` through T+40; new MUL after reset produces a correct product.
- Zero/identity: op_b=0 → wb_data=0 at T+33; op_a=1, op_b=0x12345678 → wb_data=0x12345678; non-MUL opcodes never raise `mul_trigger`.
